// File: rtl/mips_write_checker_if.sv
// Bus bundle between the MIPS data-memory write port, the expected-write table loader and the checker.
// The capture fields exist only when WCHK_CAPTURE_EN is defined.
interface mips_write_checker_if #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned NUM_EXP = 4
);
  localparam int unsigned IW = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
  localparam int unsigned CW = $clog2(NUM_EXP) + 1;

  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          exp_we;
  logic [IW-1:0] exp_idx;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [CW-1:0] exp_len;
  logic          start;
  logic          done;
  logic          pass;
  logic          fail;
  logic          timeout;
  logic [CW-1:0] match_cnt;
`ifdef WCHK_CAPTURE_EN
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [IW-1:0] fail_idx;
`endif

  modport master (
    output memwrite, dataadr, writedata, exp_we, exp_idx, exp_addr, exp_data, exp_len, start,
`ifdef WCHK_CAPTURE_EN
    input  fail_addr, fail_data, fail_idx,
`endif
    input  done, pass, fail, timeout, match_cnt
  );

  modport slave (
    input  memwrite, dataadr, writedata, exp_we, exp_idx, exp_addr, exp_data, exp_len, start,
`ifdef WCHK_CAPTURE_EN
    output fail_addr, fail_data, fail_idx,
`endif
    output done, pass, fail, timeout, match_cnt
  );
endinterface

// File: rtl/mips_write_checker.sv
// In-order checker of MIPS data-memory writes against a loadable expected-write table, with a cycle budget.
// Optional WCHK_CAPTURE_EN adds registered capture of the offending write on FAIL.
module mips_write_checker #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned NUM_EXP     = 4,
  parameter int unsigned IGNORE_ADDR = 80,
  parameter int unsigned CYCLE_LIMIT = 80
) (
  input logic                clk,
  input logic                reset,
  mips_write_checker_if.slave bus
);
  localparam int unsigned IW = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
  localparam int unsigned CW = $clog2(NUM_EXP) + 1;
  localparam int unsigned TW = $clog2(CYCLE_LIMIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] len_q, len_d;
  logic [TW-1:0] cycle_q, cycle_d;
  logic [AW-1:0] tbl_addr_q [NUM_EXP];
  logic [DW-1:0] tbl_data_q [NUM_EXP];
  logic          done_q, pass_q, fail_q, timeout_q;

  logic [CW-1:0] len_clamp;
  logic [IW-1:0] ptr_idx;
  logic          tbl_we, wr_hit, wr_match, at_limit, last_entry;

  assign len_clamp  = (bus.exp_len > CW'(NUM_EXP)) ? CW'(NUM_EXP) : bus.exp_len;
  assign ptr_idx    = IW'(ptr_q);
  assign wr_hit     = bus.memwrite && (bus.dataadr != AW'(IGNORE_ADDR));
  assign wr_match   = (bus.dataadr == tbl_addr_q[ptr_idx]) && (bus.writedata == tbl_data_q[ptr_idx]);
  assign at_limit   = (cycle_q == TW'(CYCLE_LIMIT));
  assign last_entry = (ptr_q == len_q - CW'(1));
  assign tbl_we     = (state_q != S_RUN) && bus.exp_we && (32'(bus.exp_idx) < NUM_EXP);

  // Next-state: a resolving write outranks the cycle budget on the same edge
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cycle_d = cycle_q;
    case (state_q)
      S_RUN: begin
        cycle_d = at_limit ? cycle_q : cycle_q + TW'(1);
        if (wr_hit && wr_match) begin
          ptr_d = ptr_q + CW'(1);
          if (last_entry)    state_d = S_PASS;
          else if (at_limit) state_d = S_TIMEOUT;
        end else if (wr_hit) begin
          state_d = S_FAIL;
        end else if (at_limit) begin
          state_d = S_TIMEOUT;
        end
      end
      default: begin
        if (bus.start) begin
          len_d   = len_clamp;
          ptr_d   = '0;
          cycle_d = '0;
          state_d = (len_clamp == '0) ? S_PASS : S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      len_q     <= '0;
      cycle_q   <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      cycle_q   <= cycle_d;
      done_q    <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
      pass_q    <= (state_d == S_PASS);
      fail_q    <= (state_d == S_FAIL);
      timeout_q <= (state_d == S_TIMEOUT);
    end
  end

  // Expected-write table, writable only outside RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_EXP); i++) begin
        tbl_addr_q[i] <= '0;
        tbl_data_q[i] <= '0;
      end
    end else if (tbl_we) begin
      tbl_addr_q[bus.exp_idx] <= bus.exp_addr;
      tbl_data_q[bus.exp_idx] <= bus.exp_data;
    end
  end

  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.timeout   = timeout_q;
  assign bus.match_cnt = ptr_q;

`ifdef WCHK_CAPTURE_EN
  logic [AW-1:0] fail_addr_q;
  logic [DW-1:0] fail_data_q;
  logic [IW-1:0] fail_idx_q;

  // Snapshot the offending write on entry to FAIL; cleared on re-arm
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_idx_q  <= '0;
    end else if (state_q == S_RUN && state_d == S_FAIL) begin
      fail_addr_q <= bus.dataadr;
      fail_data_q <= bus.writedata;
      fail_idx_q  <= ptr_idx;
    end else if (state_q != S_RUN && bus.start) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_idx_q  <= '0;
    end
  end

  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_data = fail_data_q;
  assign bus.fail_idx  = fail_idx_q;
`endif
endmodule

// File: tb/tb_mips_write_checker.sv
// Bench for mips_write_checker: directed scenarios plus randomized write streams against an in-order outcome model.
module tb_mips_write_checker;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NE = 4;
  localparam int unsigned CL = 80;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mips_write_checker_if #(.AW(AW), .DW(DW), .NUM_EXP(NE)) bus ();

  mips_write_checker #(.AW(AW), .DW(DW), .NUM_EXP(NE), .IGNORE_ADDR(80), .CYCLE_LIMIT(CL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    bus.exp_we = 1'b1; bus.exp_idx = 2'(idx); bus.exp_addr = a; bus.exp_data = d;
    @(negedge clk);
    bus.exp_we = 1'b0;
  endtask

  task automatic arm(input int len);
    bus.start = 1'b1; bus.exp_len = 3'(len);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
    @(negedge clk);
    bus.memwrite = 1'b0;
  endtask

  function automatic logic [6:0] obs();
    return {bus.done, bus.pass, bus.fail, bus.timeout, bus.match_cnt};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if (obs() !== 7'd0) $display("FAIL reset_hold: got %b want %b", obs(), 7'd0);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (obs() !== 7'd0) $display("FAIL reset_idle: got %b want %b", obs(), 7'd0);
    else n_pass++;
  endtask

  task automatic test_pass_ignore();
    load(0, 84, 7);
    arm(1);
    wr(80, 99);
    n_total++;
    if (obs() !== 7'd0) $display("FAIL ignore_write: got %b want %b", obs(), 7'd0);
    else n_pass++;
    wr(84, 7);
    n_total++;
    if (obs() !== {4'b1100, 3'd1}) $display("FAIL single_pass: got %b want %b", obs(), {4'b1100, 3'd1});
    else n_pass++;
  endtask

  task automatic test_fail();
    arm(1);
    wr(84, 5);
    n_total++;
    if (obs() !== {4'b1010, 3'd0}) $display("FAIL mismatch: got %b want %b", obs(), {4'b1010, 3'd0});
    else n_pass++;
`ifdef WCHK_CAPTURE_EN
    n_total++;
    if ({bus.fail_addr, bus.fail_data, bus.fail_idx} !== {32'd84, 32'd5, 2'd0})
      $display("FAIL capture: got %0d/%0d/%0d want 84/5/0", bus.fail_addr, bus.fail_data, bus.fail_idx);
    else n_pass++;
`endif
  endtask

  task automatic test_timeout();
    arm(1);
    repeat (CL) @(negedge clk);
    n_total++;
    if (obs() !== 7'd0) $display("FAIL timeout_early: got %b want %b", obs(), 7'd0);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (obs() !== {4'b1001, 3'd0}) $display("FAIL timeout_edge: got %b want %b", obs(), {4'b1001, 3'd0});
    else n_pass++;
  endtask

  task automatic test_limit_race();
    load(0, 84, 7); load(1, 88, 3); load(2, 92, 1);
    arm(3);
    wr(84, 7);
    wr(88, 3);
    repeat (CL - 2) @(negedge clk);
    n_total++;
    if (obs() !== {4'b0000, 3'd2}) $display("FAIL race_pre: got %b want %b", obs(), {4'b0000, 3'd2});
    else n_pass++;
    wr(92, 1);
    n_total++;
    if (obs() !== {4'b1100, 3'd3}) $display("FAIL race_final: got %b want %b", obs(), {4'b1100, 3'd3});
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    load(0, 84, 7); load(1, 88, 3);
    arm(2);
    wr(84, 7);
    n_total++;
    if (obs() !== {4'b0000, 3'd1}) $display("FAIL mid_run_match: got %b want %b", obs(), {4'b0000, 3'd1});
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (obs() !== 7'd0) $display("FAIL async_reset: got %b want %b", obs(), 7'd0);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    arm(1);
    wr(84, 7);
    n_total++;
    if (obs() !== {4'b1010, 3'd0}) $display("FAIL table_cleared: got %b want %b", obs(), {4'b1010, 3'd0});
    else n_pass++;
  endtask

  task automatic test_run_load_and_clamp();
    for (int i = 0; i < 4; i++) load(i, 32'(100 + 4 * i), 32'(i + 1));
    arm(4);
    load(0, 200, 200);
    for (int i = 0; i < 4; i++) wr(32'(100 + 4 * i), 32'(i + 1));
    n_total++;
    if (obs() !== {4'b1100, 3'd4}) $display("FAIL run_load_ignored: got %b want %b", obs(), {4'b1100, 3'd4});
    else n_pass++;
    arm(0);
    n_total++;
    if (obs() !== {4'b1100, 3'd0}) $display("FAIL len_zero: got %b want %b", obs(), {4'b1100, 3'd0});
    else n_pass++;
    arm(7);
    for (int i = 0; i < 4; i++) wr(32'(100 + 4 * i), 32'(i + 1));
    n_total++;
    if (obs() !== {4'b1100, 3'd4}) $display("FAIL len_clamp: got %b want %b", obs(), {4'b1100, 3'd4});
    else n_pass++;
  endtask

  // Outcome model: walk the write stream in order; res 0=running 1=pass 2=fail 3=timeout
  task automatic test_random();
    logic [31:0] ea[4];
    logic [31:0] ed[4];
    for (int it = 0; it < 24; it++) begin
      int len = int'($urandom_range(1, 4));
      bit slow = (it % 4) == 3;
      int m = 0;
      int res = 0;
      int k = 0;
      for (int i = 0; i < 4; i++) begin
        ea[i] = 32'(84 + 4 * $urandom_range(0, 7));
        ed[i] = $urandom;
        load(i, ea[i], ed[i]);
      end
      arm(len);
      while (res == 0) begin
        int r;
        k++;
        r = slow ? (($urandom_range(0, 19) == 0) ? 6 : 0) : int'($urandom_range(0, 9));
        if (r <= 3) begin
          @(negedge clk);
          if (k - 1 == int'(CL)) res = 3;
        end else if (r <= 5) begin
          wr(80, $urandom);
          if (k - 1 == int'(CL)) res = 3;
        end else if (r <= 8) begin
          wr(ea[m], ed[m]);
          m++;
          if (m == len) res = 1;
          else if (k - 1 == int'(CL)) res = 3;
        end else begin
          wr(ea[m], ed[m] ^ 32'h1);
          res = 2;
        end
        n_total++;
        if (obs() !== {res != 0, res == 1, res == 2, res == 3, 3'(m)})
          $display("FAIL random it%0d cyc%0d: got %b want %b", it, k, obs(),
                   {res != 0, res == 1, res == 2, res == 3, 3'(m)});
        else n_pass++;
      end
    end
  endtask

  initial begin
    bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;
    bus.exp_we = 1'b0; bus.exp_idx = '0; bus.exp_addr = '0; bus.exp_data = '0;
    bus.exp_len = '0; bus.start = 1'b0;
    test_reset();
    test_pass_ignore();
    test_fail();
    test_timeout();
    test_limit_race();
    test_reset_mid_run();
    test_run_load_and_clamp();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
